inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 25 ++
 rtl/inst_fetch.sv | 102 ++++++++++
 tb/tb_inst_fetch.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory handshake, pipeline control inputs
// and the IF/ID-facing instruction outputs.
interface inst_fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ready;
    logic        rom_rvalid;
    logic [31:0] rom_rdata;
    logic [31:0] inst;
    logic [31:0] pc_addr;
    logic        inst_valid;

    modport master (
        input  stall, branch_taken, branch_target, rom_ready, rom_rvalid, rom_rdata,
        output rom_req, rom_addr, inst, pc_addr, inst_valid
    );

    modport slave (
        output stall, branch_taken, branch_target, rom_ready, rom_rvalid, rom_rdata,
        input  rom_req, rom_addr, inst, pc_addr, inst_valid
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding memory request at a time, with a hold
// buffer for responses that arrive while decode is stalled.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master fetch_bus
);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] target;

    assign target = {fetch_bus.branch_target[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StReq;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            hold_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        pc_d                 = pc_q;
        discard_d            = discard_q;
        hold_d               = hold_q;
        fetch_bus.rom_req    = 1'b0;
        fetch_bus.rom_addr   = pc_q;
        fetch_bus.inst       = NOP_INST;
        fetch_bus.pc_addr    = pc_q;
        fetch_bus.inst_valid = 1'b0;

        unique case (state_q)
            StReq: begin
                // Issue regardless of stall; stall only gates delivery.
                fetch_bus.rom_req = 1'b1;
                if (fetch_bus.branch_taken) begin
                    pc_d = target;
                    if (fetch_bus.rom_ready) begin
                        discard_d = 1'b1;
                        state_d   = StWait;
                    end
                end else if (fetch_bus.rom_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (fetch_bus.branch_taken) begin
                    pc_d = target;
                    if (fetch_bus.rom_rvalid) begin
                        discard_d = 1'b0;
                        state_d   = StReq;
                    end else begin
                        // Response still in flight belongs to the old path.
                        discard_d = 1'b1;
                    end
                end else if (fetch_bus.rom_rvalid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = StReq;
                    end else if (fetch_bus.stall) begin
                        hold_d  = fetch_bus.rom_rdata;
                        state_d = StHold;
                    end else begin
                        fetch_bus.inst       = fetch_bus.rom_rdata;
                        fetch_bus.inst_valid = 1'b1;
                        pc_d                 = pc_q + 32'd4;
                        state_d              = StReq;
                    end
                end
            end
            StHold: begin
                if (fetch_bus.branch_taken) begin
                    pc_d      = target;
                    discard_d = 1'b0;
                    state_d   = StReq;
                end else if (!fetch_bus.stall) begin
                    fetch_bus.inst       = hold_q;
                    fetch_bus.inst_valid = 1'b1;
                    pc_d                 = pc_q + 32'd4;
                    state_d              = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed per-cycle vector bench for inst_fetch plus a mid-transaction reset sequence.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    inst_fetch_if bus ();

    inst_fetch #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic iv, input logic [31:0] inst, input logic [31:0] pc);
        chk({tag, ".rom_req"}, {31'b0, bus.rom_req}, {31'b0, req});
        chk({tag, ".rom_addr"}, bus.rom_addr, addr);
        chk({tag, ".inst_valid"}, {31'b0, bus.inst_valid}, {31'b0, iv});
        chk({tag, ".inst"}, bus.inst, inst);
        chk({tag, ".pc_addr"}, bus.pc_addr, pc);
    endtask

    task automatic add(input logic st, input logic br, input logic [31:0] tgt, input logic rdy,
                       input logic rv, input logic [31:0] rd, input logic e_req,
                       input logic [31:0] e_addr, input logic e_iv, input logic [31:0] e_inst,
                       input logic [31:0] e_pc);
        vec_t v;
        v.stall = st; v.br = br; v.tgt = tgt; v.rdy = rdy; v.rv = rv; v.rdata = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                         input logic rdy, input logic rv, input logic [31:0] rd);
        bus.stall = st; bus.branch_taken = br; bus.branch_target = tgt;
        bus.rom_ready = rdy; bus.rom_rvalid = rv; bus.rom_rdata = rd;
    endtask

    initial begin
        //  st br tgt            rdy rv rdata           req addr           iv inst           pc_addr
        add(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h0,          0, NOP,           32'h0);
        add(0, 0, 32'h0,         0, 1, 32'h1111_1111,  0, 32'h0,          1, 32'h1111_1111, 32'h0);
        add(0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h4,          0, NOP,           32'h4);
        add(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h4,          0, NOP,           32'h4);
        add(0, 0, 32'h0,         0, 1, 32'h2222_2222,  0, 32'h4,          1, 32'h2222_2222, 32'h4);
        add(1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h8,          0, NOP,           32'h8);
        add(1, 0, 32'h0,         0, 1, 32'hAAAA_0001,  0, 32'h8,          0, NOP,           32'h8);
        add(1, 0, 32'h0,         0, 0, 32'h0,          0, 32'h8,          0, NOP,           32'h8);
        add(1, 0, 32'h0,         0, 0, 32'h0,          0, 32'h8,          0, NOP,           32'h8);
        add(0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h8,          1, 32'hAAAA_0001, 32'h8);
        add(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'hC,          0, NOP,           32'hC);
        add(0, 1, 32'h0000_0103, 0, 0, 32'h0,          0, 32'hC,          0, NOP,           32'hC);
        add(0, 0, 32'h0,         0, 1, 32'hDEAD_BEEF,  0, 32'h100,        0, NOP,           32'h100);
        add(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h100,        0, NOP,           32'h100);
        add(0, 0, 32'h0,         0, 1, 32'h3333_3333,  0, 32'h100,        1, 32'h3333_3333, 32'h100);
        add(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h104,        0, NOP,           32'h104);
        add(0, 1, 32'h0000_0200, 0, 1, 32'h4444_4444,  0, 32'h104,        0, NOP,           32'h104);
        add(1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h200,        0, NOP,           32'h200);
        add(1, 0, 32'h0,         0, 1, 32'h5555_5555,  0, 32'h200,        0, NOP,           32'h200);
        add(1, 1, 32'h0000_0300, 0, 0, 32'h0,          0, 32'h200,        0, NOP,           32'h200);
        add(0, 1, 32'hFFFF_FFFE, 0, 0, 32'h0,          1, 32'h300,        0, NOP,           32'h300);
        add(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, NOP,           32'hFFFF_FFFC);
        add(0, 0, 32'h0,         0, 1, 32'h6666_6666,  0, 32'hFFFF_FFFC,  1, 32'h6666_6666, 32'hFFFF_FFFC);
        add(0, 1, 32'h0000_0500, 1, 0, 32'h0,          1, 32'h0,          0, NOP,           32'h0);
        add(0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h500,        0, NOP,           32'h500);
        add(0, 0, 32'h0,         0, 1, 32'h7777_7777,  0, 32'h500,        0, NOP,           32'h500);
        add(0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h500,        0, NOP,           32'h500);
        add(0, 0, 32'h0,         0, 1, 32'h8888_8888,  0, 32'h500,        1, 32'h8888_8888, 32'h500);
        add(0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h504,        0, NOP,           32'h504);

        drive(0, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_outs("reset", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].rdy, vecs[i].rv,
                  vecs[i].rdata);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
                     vecs[i].e_inst, vecs[i].e_pc);
            @(negedge clk);
        end

        // Reset while a request is outstanding: accept at pc 0x504, then reset in S_WAIT.
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 1, 32'h9999_9999);
        rst = 1'b1;
        #1;
        chk_outs("midrst", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #1;
        chk_outs("postrst0", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        @(negedge clk);
        #1;
        chk_outs("postrst1", 1'b1, 32'h0, 1'b0, NOP, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
